i2s_tx_fifo: RTL and testbench
==============================

Name: i2s_tx_fifo

Overview:
Downstream stage of the 8-channel audio mixer. Accepts mixed stereo samples, each carrying 16-bit left and 16-bit right words, and buffers them in a small FIFO. Serialises them as a standard I2S master stream (BCLK, LRCLK, SD) for the external DAC. Flags underruns so firmware can read them over the SPI control path.

Parameters:
CLK_DIV, 8, clk_i cycles per BCLK half-period; legal range is >= 2.
FIFO_DEPTH, 8, sample FIFO depth in stereo frames; must be a power of 2 and >= 2.

Ports:
clk_i  in  1  single block clock; the system connects it to clk_50MHz.
rst_ni  in  1  reset, asynchronous assert, active-low.
en_i  in  1  enables the serialiser; the FIFO accepts samples regardless of en_i.
smp_dat_i  in  32  stereo sample: [31:16] is left, [15:0] is right, both two's complement.
smp_valid_i  in  1  upstream has a sample on smp_dat_i.
smp_ready_o  out  1  block can accept a sample.
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  number of stored frames, 0..FIFO_DEPTH.
underrun_o  out  1  sticky underrun flag.
underrun_clr_i  in  1  clears underrun_o.
i2s_bclk_o  out  1  bit clock.
i2s_lrclk_o  out  1  word select: 0 = left, 1 = right.
i2s_sd_o  out  1  serial data.

Behaviour:
- Reset, asserted while rst_ni = 0:
  - FIFO is emptied and fifo_level_o = 0.
  - smp_ready_o = 1 and underrun_o = 0.
  - i2s_bclk_o, i2s_lrclk_o and i2s_sd_o are all 0.
  - Divider counter = 0, bit counter bc = 31, shift register = 0.
- Reset mid-frame: outputs go to their reset values immediately and asynchronously, with no completion of the current frame.
- FIFO:
  - A push occurs on a clk_i edge where smp_valid_i && smp_ready_o.
  - smp_ready_o = (level != FIFO_DEPTH), combinational from the registered level.
  - While full, a push is refused even if a pop occurs in the same cycle.
  - A pop is requested by the serialiser only.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - There is no empty bypass: a pushed sample is first poppable on the next cycle.
  - All outputs are registered except smp_ready_o.
- Divider (en_i = 1):
  - Counter runs 0..CLK_DIV-1.
  - At the terminal count, i2s_bclk_o toggles and the counter returns to 0.
  - A BCLK falling event is the cycle in which bclk toggles 1->0; a rising event is 0->1.
- Frame:
  - 32 BCLK per frame.
  - On each falling event, bc <= (bc+1) mod 32, i2s_lrclk_o <= (new bc >= 16), and i2s_sd_o is updated. The I2S 1-bit delay applies.
  - Falling event entering bc = 0:
    - If the FIFO is non-empty, pop the head into the frame register {L,R}.
    - If the FIFO is empty, load 0 and set underrun_o.
    - i2s_sd_o still drives R[0] of the previous frame.
  - bc 1..16: i2s_sd_o = L[16-bc], so L MSB appears at bc = 1.
  - bc 17..31: i2s_sd_o = R[32-bc].
  - The next frame's bc 0 drives R[0].
  - The DAC samples SD and LRCLK on rising events.
- en_i:
  - Falling en_i takes effect on the next clk_i edge, mid-frame: outputs forced to 0, divider to 0, bc to 31, frame register kept.
  - Rising en_i: the first falling event occurs 2*CLK_DIV cycles later and pops.
  - No pops occur while disabled, and no underrun is flagged while disabled.
- Underrun: set has priority over underrun_clr_i in the same cycle.
- Frame rate is clk_i / (64*CLK_DIV); with the defaults that is 50 MHz / 512 ≈ 97.66 kHz.

Test Plan:
- Reset: assert rst_ni = 0 mid-frame with 3 frames queued -> asynchronously bclk/lrclk/sd = 0, fifo_level_o = 0, smp_ready_o = 1, underrun_o = 0.
- Single frame: push 0xA5A5_3C3C, then en_i = 1 -> SD sampled on rising events at bc 1..16 is 1010010110100101, and at bc 17..31 plus next bc 0 is 0011110000111100. LRCLK is 0 for bc 0..15 and 1 for bc 16..31.
- Full FIFO with en_i = 0: push FIFO_DEPTH+1 frames back-to-back -> level reaches 8 and smp_ready_o = 0 after the 8th push. The 9th is held off and accepted one cycle after the first pop once enabled. Output order matches push order.
- Underrun: enable with the FIFO empty -> all-zero frame, underrun_o = 1 after the first frame-start event. Pulse underrun_clr_i in the same cycle as a second empty pop -> underrun_o stays 1.
- Simultaneous push/pop at level 1 -> level stays 1. A push at level 0 in the pop cycle -> underrun set, and the sample is output in the following frame.
- en_i toggle: drop en_i at bc = 20, re-enable 100 cycles later -> outputs 0 while disabled. After re-enable the next frame starts with a fresh pop after 2*CLK_DIV cycles, and no partial frame is emitted.

Source files
------------

// File: rtl/i2s_tx_fifo.sv
// I2S master transmitter with a small stereo-frame FIFO in front of it.
// Pops one {L,R} frame per 32-BCLK frame and flags a sticky underrun when it finds the FIFO empty.
module i2s_tx_fifo #(
  parameter int unsigned CLK_DIV    = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic [31:0]                   smp_dat_i,
  input  logic                          smp_valid_i,
  output logic                          smp_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underrun_o,
  input  logic                          underrun_clr_i,
  output logic                          i2s_bclk_o,
  output logic                          i2s_lrclk_o,
  output logic                          i2s_sd_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;

  logic [CW-1:0] div_cnt_q;
  logic [4:0]    bc_q;
  logic [31:0]   frame_q;
  logic          bclk_q;
  logic          lrclk_q;
  logic          sd_q;
  logic          underrun_q;

  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          div_tc;
  logic          fall_ev;
  logic          frame_start;
  logic [4:0]    bc_nxt;
  logic [4:0]    sd_idx;

  // Event decode; frame_start only fires while enabled because div_tc includes en_i.
  always_comb begin
    fifo_empty  = (level_q == '0);
    smp_ready_o = (level_q != LW'(FIFO_DEPTH));
    push        = smp_valid_i && smp_ready_o;
    div_tc      = en_i && (div_cnt_q == CW'(CLK_DIV - 1));
    fall_ev     = div_tc && bclk_q;
    bc_nxt      = bc_q + 5'd1;
    frame_start = fall_ev && (bc_nxt == 5'd0);
    pop         = frame_start && !fifo_empty;
    // bit 32-bc of {L,R}; bc = 0 wraps to bit 0 of the outgoing frame (I2S one-bit delay)
    sd_idx      = 5'd0 - bc_nxt;
  end

  // FIFO pointers and level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= smp_dat_i;
  end

  // BCLK divider and serialiser; disabling parks the frame at bc = 31 but keeps frame_q
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sd_q      <= 1'b0;
      bc_q      <= 5'd31;
      frame_q   <= '0;
    end else if (!en_i) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sd_q      <= 1'b0;
      bc_q      <= 5'd31;
    end else begin
      if (div_tc) begin
        div_cnt_q <= '0;
        bclk_q    <= !bclk_q;
      end else begin
        div_cnt_q <= div_cnt_q + CW'(1);
      end
      if (fall_ev) begin
        bc_q    <= bc_nxt;
        lrclk_q <= bc_nxt[4];
        sd_q    <= frame_q[sd_idx];
        if (frame_start) frame_q <= pop ? mem[rd_ptr_q] : '0;
      end
    end
  end

  // Sticky underrun; a new underrun wins over a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       underrun_q <= 1'b0;
    else if (frame_start && fifo_empty) underrun_q <= 1'b1;
    else if (underrun_clr_i)           underrun_q <= 1'b0;
  end

  assign fifo_level_o = level_q;
  assign underrun_o   = underrun_q;
  assign i2s_bclk_o   = bclk_q;
  assign i2s_lrclk_o  = lrclk_q;
  assign i2s_sd_o     = sd_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Bench for i2s_tx_fifo: directed stimulus queues expected frames; a monitor
// rebuilds frames from SD/LRCLK on rising BCLK and scores them against the queue.
module tb_i2s_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic [31:0] smp_dat_i = '0;
  logic        smp_valid_i = 1'b0;
  logic        smp_ready_o;
  logic [3:0]  fifo_level_o;
  logic        underrun_o;
  logic        underrun_clr_i = 1'b0;
  logic        i2s_bclk_o;
  logic        i2s_lrclk_o;
  logic        i2s_sd_o;

  i2s_tx_fifo #(.CLK_DIV(8), .FIFO_DEPTH(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .smp_dat_i      (smp_dat_i),
    .smp_valid_i    (smp_valid_i),
    .smp_ready_o    (smp_ready_o),
    .fifo_level_o   (fifo_level_o),
    .underrun_o     (underrun_o),
    .underrun_clr_i (underrun_clr_i),
    .i2s_bclk_o     (i2s_bclk_o),
    .i2s_lrclk_o    (i2s_lrclk_o),
    .i2s_sd_o       (i2s_sd_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          frames_done = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d, input bit expect_out);
    int w;
    w = 0;
    smp_valid_i = 1'b1;
    smp_dat_i   = d;
    while (!smp_ready_o && w < 2000) begin
      tick(1);
      w++;
    end
    check("push_ready_timeout", 32'(smp_ready_o), 32'd1);
    tick(1);
    smp_valid_i = 1'b0;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic wait_frames(input int base, input int n);
    int w;
    w = 0;
    while (frames_done < base + n && w < n * 600 + 200) begin
      tick(1);
      w++;
    end
    check("frames_timeout", 32'(frames_done >= base + n), 32'd1);
  endtask

  task automatic run_frames(input int n);
    int base;
    base = frames_done;
    en_i = 1'b1;
    wait_frames(base, n);
    en_i = 1'b0;
    tick(2);
  endtask

  task automatic clear_underrun();
    underrun_clr_i = 1'b1;
    tick(1);
    underrun_clr_i = 1'b0;
  endtask

  // Monitor: frame bits live on rising BCLK at bc 1..31 plus the next bc 0
  int          mbc = 31;
  logic        have = 1'b0;
  logic        lr_ok = 1'b1;
  logic        prev_bclk = 1'b0;
  logic        en_prev = 1'b0;
  logic        en_used;
  logic [31:0] word = '0;
  logic [31:0] exp_word;

  always @(negedge clk) begin
    if (!rst_ni) begin
      mbc = 31; have = 1'b0; prev_bclk = 1'b0; en_prev = 1'b0;
    end else begin
      en_used = en_prev;
      en_prev = en_i;
      if (!en_used) begin
        mbc  = 31;
        have = 1'b0;
      end else if (prev_bclk && !i2s_bclk_o) begin
        mbc = (mbc + 1) % 32;
      end else if (!prev_bclk && i2s_bclk_o) begin
        if (mbc == 1) begin
          have = 1'b1; lr_ok = 1'b1; word = '0;
        end
        if (i2s_lrclk_o !== 1'(mbc >= 16)) lr_ok = 1'b0;
        if (mbc == 0) begin
          if (have) begin
            word[0] = i2s_sd_o;
            frames_done++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL frame_unexpected: got %h, no frame expected", word);
            end else begin
              exp_word = exp_q.pop_front();
              check("frame_data", word, exp_word);
            end
            check("frame_lrclk", 32'(lr_ok), 32'd1);
          end
          have = 1'b0;
        end else begin
          word[32-mbc] = i2s_sd_o;
        end
      end
      prev_bclk = i2s_bclk_o;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    int bad;

    // Reset values
    tick(3);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    check("rst_ready", 32'(smp_ready_o), 32'd1);
    check("rst_underrun", 32'(underrun_o), 32'd0);
    check("rst_i2s", {29'd0, i2s_bclk_o, i2s_lrclk_o, i2s_sd_o}, 32'd0);
    rst_ni = 1'b1;
    tick(2);

    // Asynchronous reset mid-frame with frames queued
    push(32'h1234_5678, 1'b1);
    push(32'h8765_4321, 1'b1);
    push(32'h0F0F_F0F0, 1'b1);
    en_i = 1'b1;
    tick(600);
    check("pre_rst_level", 32'(fifo_level_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_i2s", {29'd0, i2s_bclk_o, i2s_lrclk_o, i2s_sd_o}, 32'd0);
    check("mid_rst_level", 32'(fifo_level_o), 32'd0);
    check("mid_rst_ready", 32'(smp_ready_o), 32'd1);
    check("mid_rst_underrun", 32'(underrun_o), 32'd0);
    en_i = 1'b0;
    exp_q.delete();
    tick(2);
    rst_ni = 1'b1;
    tick(2);

    // Single frame 0xA5A5_3C3C
    push(32'hA5A5_3C3C, 1'b1);
    run_frames(1);
    check("single_trailing_underrun", 32'(underrun_o), 32'd1);
    clear_underrun();
    check("underrun_cleared", 32'(underrun_o), 32'd0);

    // Full FIFO while disabled; 9th push held off until the first pop
    for (int i = 0; i < 8; i++) push(32'h0101_0101 * (i + 1), 1'b1);
    check("full_level", 32'(fifo_level_o), 32'd8);
    check("full_ready", 32'(smp_ready_o), 32'd0);
    smp_valid_i = 1'b1;
    smp_dat_i   = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    base = frames_done;
    en_i = 1'b1;
    w = 0;
    while (!smp_ready_o && w < 100) begin
      tick(1);
      w++;
    end
    check("first_pop_latency", 32'(w), 32'd16);
    check("level_after_pop", 32'(fifo_level_o), 32'd7);
    tick(1);
    smp_valid_i = 1'b0;
    check("level_after_9th", 32'(fifo_level_o), 32'd8);
    wait_frames(base, 9);
    en_i = 1'b0;
    tick(2);
    clear_underrun();

    // Underrun on empty enable; clear coinciding with a second empty pop loses
    base = frames_done;
    exp_q.push_back(32'h0);
    en_i = 1'b1;
    tick(15);
    check("underrun_before_start", 32'(underrun_o), 32'd0);
    tick(1);
    check("underrun_at_start", 32'(underrun_o), 32'd1);
    underrun_clr_i = 1'b1;
    tick(1);
    underrun_clr_i = 1'b0;
    check("underrun_clear_works", 32'(underrun_o), 32'd0);
    tick(510);
    underrun_clr_i = 1'b1;
    tick(1);
    underrun_clr_i = 1'b0;
    check("underrun_set_beats_clr", 32'(underrun_o), 32'd1);
    wait_frames(base, 1);
    en_i = 1'b0;
    tick(2);
    clear_underrun();
    tick(50);
    check("no_underrun_disabled", 32'(underrun_o), 32'd0);

    // Push and pop together at level 1, then push at level 0 in the pop cycle
    push(32'h1111_AAAA, 1'b1);
    base = frames_done;
    en_i = 1'b1;
    tick(15);
    smp_valid_i = 1'b1;
    smp_dat_i   = 32'h2222_BBBB;
    exp_q.push_back(32'h2222_BBBB);
    tick(1);
    smp_valid_i = 1'b0;
    check("pushpop_level1", 32'(fifo_level_o), 32'd1);
    tick(511);
    check("mid_level", 32'(fifo_level_o), 32'd1);
    check("mid_underrun", 32'(underrun_o), 32'd0);
    tick(512);
    check("pre_empty_pop_level", 32'(fifo_level_o), 32'd0);
    exp_q.push_back(32'h0);
    smp_valid_i = 1'b1;
    smp_dat_i   = 32'h3333_CCCC;
    exp_q.push_back(32'h3333_CCCC);
    tick(1);
    smp_valid_i = 1'b0;
    check("empty_pop_underrun", 32'(underrun_o), 32'd1);
    check("empty_pop_level", 32'(fifo_level_o), 32'd1);
    wait_frames(base, 4);
    en_i = 1'b0;
    tick(2);
    clear_underrun();

    // Drop en_i at bc = 20; the partial frame is discarded and the next enable pops fresh
    push(32'h4444_DDDD, 1'b0);
    push(32'h5555_EEEE, 1'b1);
    en_i = 1'b1;
    tick(340);
    en_i = 1'b0;
    tick(1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i2s_bclk_o || i2s_lrclk_o || i2s_sd_o) bad++;
      tick(1);
    end
    check("disabled_outputs_zero", 32'(bad), 32'd0);
    check("disabled_level", 32'(fifo_level_o), 32'd1);
    base = frames_done;
    en_i = 1'b1;
    tick(15);
    check("reenable_before_pop", 32'(fifo_level_o), 32'd1);
    tick(1);
    check("reenable_pop", 32'(fifo_level_o), 32'd0);
    wait_frames(base, 1);
    en_i = 1'b0;
    tick(2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
